// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/result and ALU drive bundle for alu_seq_ctrl
// slave  : the sequencer (consumes Start/Mode/OpA/OpB and ALU sum, drives results and ALU controls)
// master : the surrounding decode unit plus shared ALU
interface alu_seq_ctrl_if;
    logic        Start;
    logic        Mode;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic        Busy;
    logic        Done;
    logic [15:0] ResultHi;
    logic [15:0] ResultLo;
    logic        DivByZero;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic        AluAInvert;
    logic        AluBNegate;
    logic [1:0]  AluOp;
    logic [15:0] AluResult;
    logic        AluCarryOut;

    modport slave (
        input  Start, Mode, OpA, OpB, AluResult, AluCarryOut,
        output Busy, Done, ResultHi, ResultLo, DivByZero,
               AluA, AluB, AluAInvert, AluBNegate, AluOp
    );

    modport master (
        output Start, Mode, OpA, OpB, AluResult, AluCarryOut,
        input  Busy, Done, ResultHi, ResultLo, DivByZero,
               AluA, AluB, AluAInvert, AluBNegate, AluOp
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 16-cycle shift-add multiply / restoring divide sequencer driving a shared 16-bit ALU
// Ports: clk, rst_n (async active-low), bus (alu_seq_ctrl_if.slave):
//   Start/Mode/OpA/OpB request, Busy/Done/ResultHi/ResultLo/DivByZero status,
//   AluA/AluB/AluAInvert/AluBNegate/AluOp ALU drive, AluResult/AluCarryOut ALU return.
// Build option: define ALU_SEQ_DIV_EN to add unsigned divide (Mode=1); otherwise every request is MUL.
module alu_seq_ctrl (
    input logic clk,
    input logic rst_n,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] hi_q, lo_q, m_q;
    logic        busy_q, done_q;
    logic [15:0] hi_d, lo_d;
    logic        run;
    logic        div_req, dbz_req;
    assign run = state_q == RUN;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.ResultHi = hi_q;
    assign bus.ResultLo = lo_q;
    assign bus.AluAInvert = 1'b0;
    assign bus.AluOp = 2'b10;
`ifdef ALU_SEQ_DIV_EN
    logic div_q, dbz_q, take;
    logic [15:0] rsh;
    assign div_req = bus.Mode;
    assign dbz_req = bus.Mode && bus.OpB == 16'd0;
    // partial remainder shifted left with the next dividend bit; R[15] set means it already exceeds D
    assign rsh = {hi_q[14:0], lo_q[15]};
    assign take = hi_q[15] | bus.AluCarryOut;
    assign bus.DivByZero = dbz_q;
    assign bus.AluBNegate = run & div_q;
    assign bus.AluA = !run ? 16'd0 : div_q ? rsh : hi_q;
    assign bus.AluB = !run ? 16'd0 : (div_q | lo_q[0]) ? m_q : 16'd0;
    always_comb begin
        hi_d = div_q ? (take ? bus.AluResult : rsh) : {bus.AluCarryOut, bus.AluResult[15:1]};
        lo_d = div_q ? {lo_q[14:0], take} : {bus.AluResult[0], lo_q[15:1]};
    end
`else
    logic unused_mode;
    assign unused_mode = bus.Mode;
    assign div_req = 1'b0;
    assign dbz_req = 1'b0;
    assign bus.DivByZero = 1'b0;
    assign bus.AluBNegate = 1'b0;
    assign bus.AluA = run ? hi_q : 16'd0;
    assign bus.AluB = (run & lo_q[0]) ? m_q : 16'd0;
    // carry becomes the new Acc MSB; the sum LSB shifts into Q as the multiplier shifts out
    always_comb begin
        hi_d = {bus.AluCarryOut, bus.AluResult[15:1]};
        lo_d = {bus.AluResult[0], lo_q[15:1]};
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 16'd0;
            lo_q    <= 16'd0;
            m_q     <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q   <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.Start) begin
                    cnt_q  <= 4'd0;
                    busy_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    div_q  <= div_req;
                    dbz_q  <= dbz_req;
`endif
                    if (dbz_req) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hi_q    <= bus.OpA;
                        lo_q    <= 16'hFFFF;
                    end else begin
                        state_q <= RUN;
                        hi_q    <= 16'd0;
                        lo_q    <= div_req ? bus.OpA : bus.OpB;
                        m_q     <= div_req ? bus.OpB : bus.OpA;
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
